// File: rtl/rotate_affine_pipe.sv
// rtl/rotate_affine_pipe.sv - pipelined 2x2 affine coordinate mapper with frame-latched config
module rotate_affine_pipe #(
  parameter int IN_WIDTH   = 12,
  parameter int COEF_WIDTH = 12,
  parameter int FRAC_BITS  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [COEF_WIDTH-1:0]       m00,
  input  logic [COEF_WIDTH-1:0]       m01,
  input  logic [COEF_WIDTH-1:0]       m10,
  input  logic [COEF_WIDTH-1:0]       m11,
  input  logic [IN_WIDTH-1:0]         num_cols,
  input  logic [IN_WIDTH-1:0]         num_rows,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_sof,
  input  logic [IN_WIDTH-1:0]         xi,
  input  logic [IN_WIDTH-1:0]         yi,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_sof,
  output logic [IN_WIDTH+FRAC_BITS:0] xo,
  output logic [IN_WIDTH+FRAC_BITS:0] yo,
  output logic                        in_bounds
);

  localparam int OUT_WIDTH = IN_WIDTH + FRAC_BITS + 1;
  localparam int S         = COEF_WIDTH - 2 - FRAC_BITS;
  localparam int D_W       = IN_WIDTH + 1;
  localparam int P_W       = IN_WIDTH + COEF_WIDTH + 1;
  localparam int R_W       = P_W + 3;
  localparam int C_W       = IN_WIDTH - 1;

  localparam logic [COEF_WIDTH-1:0] COEF_ONE = {2'b01, {(COEF_WIDTH-2){1'b0}}};
  localparam logic signed [R_W-1:0] RND      = R_W'(1) <<< (S - 1);
  localparam logic signed [R_W-1:0] MAX_OUT  = (R_W'(1) <<< (OUT_WIDTH - 1)) - R_W'(1);
  localparam logic signed [R_W-1:0] MIN_OUT  = -(R_W'(1) <<< (OUT_WIDTH - 1));
  localparam logic [OUT_WIDTH-1:0]  MAX_CLIP = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0]  MIN_CLIP = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  // shadow config, loaded only by accepted sof beats
  logic [COEF_WIDTH-1:0] sh_m00, sh_m01, sh_m10, sh_m11;
  logic [IN_WIDTH-1:0]   sh_cols, sh_rows;

  // config that the incoming beat will carry (live on sof, shadow otherwise)
  logic [COEF_WIDTH-1:0] e_m00, e_m01, e_m10, e_m11;
  logic [IN_WIDTH-1:0]   e_cols, e_rows;
  logic                  adv, accept;

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;
  assign accept   = in_valid & adv;

  assign e_m00  = in_sof ? m00      : sh_m00;
  assign e_m01  = in_sof ? m01      : sh_m01;
  assign e_m10  = in_sof ? m10      : sh_m10;
  assign e_m11  = in_sof ? m11      : sh_m11;
  assign e_cols = in_sof ? num_cols : sh_cols;
  assign e_rows = in_sof ? num_rows : sh_rows;

  // shadow register update on accepted start-of-frame beats
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_m00  <= COEF_ONE;
      sh_m01  <= '0;
      sh_m10  <= '0;
      sh_m11  <= COEF_ONE;
      sh_cols <= '0;
      sh_rows <= '0;
    end else if (accept && in_sof) begin
      sh_m00  <= m00;
      sh_m01  <= m01;
      sh_m10  <= m10;
      sh_m11  <= m11;
      sh_cols <= num_cols;
      sh_rows <= num_rows;
    end
  end

  // stage 1: re-centre coordinates and capture the beat's config
  logic                         s1_valid, s1_sof;
  logic signed [D_W-1:0]        s1_x0, s1_y0;
  logic signed [COEF_WIDTH-1:0] s1_m00, s1_m01, s1_m10, s1_m11;
  logic [C_W-1:0]               s1_cx, s1_cy;
  logic [IN_WIDTH-1:0]          s1_cols, s1_rows;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_sof   <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_sof   <= in_valid & in_sof;
      s1_x0    <= $signed({1'b0, xi}) - $signed({2'b00, e_cols[IN_WIDTH-1:1]});
      s1_y0    <= $signed({1'b0, yi}) - $signed({2'b00, e_rows[IN_WIDTH-1:1]});
      s1_m00   <= e_m00;
      s1_m01   <= e_m01;
      s1_m10   <= e_m10;
      s1_m11   <= e_m11;
      s1_cx    <= e_cols[IN_WIDTH-1:1];
      s1_cy    <= e_rows[IN_WIDTH-1:1];
      s1_cols  <= e_cols;
      s1_rows  <= e_rows;
    end
  end

  // stage 2: the four signed matrix products
  logic                  s2_valid, s2_sof;
  logic signed [P_W-1:0] s2_p00, s2_p01, s2_p10, s2_p11;
  logic [C_W-1:0]        s2_cx, s2_cy;
  logic [IN_WIDTH-1:0]   s2_cols, s2_rows;

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_sof   <= 1'b0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_sof   <= s1_sof;
      s2_p00   <= P_W'(s1_m00) * P_W'(s1_x0);
      s2_p01   <= P_W'(s1_m01) * P_W'(s1_y0);
      s2_p10   <= P_W'(s1_m10) * P_W'(s1_x0);
      s2_p11   <= P_W'(s1_m11) * P_W'(s1_y0);
      s2_cx    <= s2_cx_next(s1_cx);
      s2_cy    <= s2_cx_next(s1_cy);
      s2_cols  <= s1_cols;
      s2_rows  <= s1_rows;
    end
  end

  function automatic logic [C_W-1:0] s2_cx_next(input logic [C_W-1:0] c);
    return c;
  endfunction

  // stage 3 datapath: round-half-up shift, re-add centre, clip, bounds test
  logic signed [R_W-1:0] sum_x, sum_y, rnd_x, rnd_y, off_x, off_y, full_x, full_y;
  logic                  sat_x, sat_y, inb_x, inb_y;
  logic [OUT_WIDTH-1:0]  clip_x, clip_y;

  always_comb begin
    sum_x  = R_W'(s2_p00) + R_W'(s2_p01);
    sum_y  = R_W'(s2_p10) + R_W'(s2_p11);
    rnd_x  = (sum_x + RND) >>> S;
    rnd_y  = (sum_y + RND) >>> S;
    off_x  = $signed(R_W'({s2_cx, {FRAC_BITS{1'b0}}}));
    off_y  = $signed(R_W'({s2_cy, {FRAC_BITS{1'b0}}}));
    full_x = rnd_x + off_x;
    full_y = rnd_y + off_y;
    sat_x  = (full_x > MAX_OUT) || (full_x < MIN_OUT);
    sat_y  = (full_y > MAX_OUT) || (full_y < MIN_OUT);
    clip_x = (full_x > MAX_OUT) ? MAX_CLIP : (full_x < MIN_OUT) ? MIN_CLIP : full_x[OUT_WIDTH-1:0];
    clip_y = (full_y > MAX_OUT) ? MAX_CLIP : (full_y < MIN_OUT) ? MIN_CLIP : full_y[OUT_WIDTH-1:0];
    inb_x  = ~clip_x[OUT_WIDTH-1] && (clip_x[OUT_WIDTH-2:0] < {s2_cols, {FRAC_BITS{1'b0}}});
    inb_y  = ~clip_y[OUT_WIDTH-1] && (clip_y[OUT_WIDTH-2:0] < {s2_rows, {FRAC_BITS{1'b0}}});
  end

  // stage 3 output registers, held while downstream stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      xo        <= '0;
      yo        <= '0;
      in_bounds <= 1'b0;
    end else if (adv) begin
      out_valid <= s2_valid;
      out_sof   <= s2_sof;
      xo        <= clip_x;
      yo        <= clip_y;
      in_bounds <= inb_x & inb_y & ~sat_x & ~sat_y;
    end
  end

endmodule

// File: tb/tb_rotate_affine_pipe.sv
// tb/tb_rotate_affine_pipe.sv - self-checking bench for rotate_affine_pipe
module tb_rotate_affine_pipe;

  localparam int FRAC = 4;
  localparam int UNIT = 64;
  localparam int HALF = 32;
  localparam longint MAXO = 65535;
  localparam longint MINO = -65536;

  typedef struct {int m00, m01, m10, m11, cols, rows;} cfg_t;
  typedef struct {int xo, yo; bit inb, sof;} res_t;
  typedef struct {cfg_t c; int x, y; res_t e;} vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] m00, m01, m10, m11, num_cols, num_rows, xi, yi;
  logic        in_valid, in_ready, in_sof, out_valid, out_ready, out_sof, in_bounds;
  logic [16:0] xo, yo;

  cfg_t live, shadow, id_cfg, id0_cfg, r90_cfg;
  res_t sbq[$];
  res_t want_q[$];
  int   checks = 0, errors = 0, n_out = 0;
  bit   last_acc, hold_chk;
  logic [16:0] h_xo, h_yo;
  logic        h_sof, h_inb;

  always #5 clk = ~clk;

  assign m00      = 12'(live.m00);
  assign m01      = 12'(live.m01);
  assign m10      = 12'(live.m10);
  assign m11      = 12'(live.m11);
  assign num_cols = 12'(live.cols);
  assign num_rows = 12'(live.rows);

  rotate_affine_pipe dut (
    .clk(clk), .reset(reset),
    .m00(m00), .m01(m01), .m10(m10), .m11(m11),
    .num_cols(num_cols), .num_rows(num_rows),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .xi(xi), .yi(yi),
    .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof),
    .xo(xo), .yo(yo), .in_bounds(in_bounds)
  );

  function automatic longint fdiv(longint a, longint b);
    longint q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // reference: centre, multiply, round half up, re-centre, clip, bounds
  function automatic res_t model(cfg_t c, int x, int y, bit sof);
    res_t r;
    longint cx, cy, x0, y0, fx, fy;
    bit sx, sy;
    cx = c.cols / 2;
    cy = c.rows / 2;
    x0 = x - cx;
    y0 = y - cy;
    fx = fdiv(longint'(c.m00) * x0 + longint'(c.m01) * y0 + HALF, UNIT) + cx * (1 << FRAC);
    fy = fdiv(longint'(c.m10) * x0 + longint'(c.m11) * y0 + HALF, UNIT) + cy * (1 << FRAC);
    sx = (fx > MAXO) || (fx < MINO);
    sy = (fy > MAXO) || (fy < MINO);
    if (fx > MAXO) fx = MAXO; else if (fx < MINO) fx = MINO;
    if (fy > MAXO) fy = MAXO; else if (fy < MINO) fy = MINO;
    r.xo  = int'(fx);
    r.yo  = int'(fy);
    r.inb = !sx && !sy && fx >= 0 && fx < c.cols * 16 && fy >= 0 && fy < c.rows * 16;
    r.sof = sof;
    return r;
  endfunction

  // one clock: drive, settle, score handshakes, advance to just after the edge
  task automatic step(bit v, bit s, int x, int y, bit rdy, bit rst);
    res_t e;
    cfg_t c;
    in_valid = v; in_sof = s; xi = 12'(x); yi = 12'(y); out_ready = rdy; reset = rst;
    #1;
    last_acc = 1'b0;
    if (!rst) begin
      if (hold_chk) begin
        checks++;
        if (out_valid !== 1'b1 || xo !== h_xo || yo !== h_yo || out_sof !== h_sof || in_bounds !== h_inb) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b xo=%0d yo=%0d sof=%0b inb=%0b, required v=1 xo=%0d yo=%0d sof=%0b inb=%0b",
                   out_valid, $signed(xo), $signed(yo), out_sof, in_bounds, $signed(h_xo), $signed(h_yo), h_sof, h_inb);
        end
      end
      hold_chk = out_valid && !out_ready;
      h_xo = xo; h_yo = yo; h_sof = out_sof; h_inb = in_bounds;
      if (out_valid && out_ready) begin
        checks++;
        n_out++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got xo=%0d yo=%0d, required no output", $signed(xo), $signed(yo));
        end else begin
          e = sbq.pop_front();
          if ($signed(xo) != e.xo || $signed(yo) != e.yo || in_bounds != e.inb || out_sof != e.sof) begin
            errors++;
            $display("FAIL output: got xo=%0d yo=%0d inb=%0b sof=%0b, required xo=%0d yo=%0d inb=%0b sof=%0b",
                     $signed(xo), $signed(yo), in_bounds, out_sof, e.xo, e.yo, e.inb, e.sof);
          end
        end
      end
      if (in_valid && in_ready) begin
        last_acc = 1'b1;
        c = s ? live : shadow;
        if (want_q.size() > 0) sbq.push_back(want_q.pop_front());
        else sbq.push_back(model(c, x, y, s));
        if (s) shadow = live;
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      sbq.delete();
      shadow   = id0_cfg;
      hold_chk = 1'b0;
    end
  endtask

  task automatic drain(bit toggle);
    for (int i = 0; i < 80 && sbq.size() > 0; i++) step(0, 0, 0, 0, toggle ? i[0] : 1'b1, 0);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d beats outstanding, required 0", sbq.size());
    end
  endtask

  vec_t vt[10];

  initial begin
    int   lat, acc, cyc, n0;
    cfg_t r32;
    id_cfg  = '{1024, 0, 0, 1024, 640, 480};
    id0_cfg = '{1024, 0, 0, 1024, 0, 0};
    r90_cfg = '{0, -1024, 1024, 0, 640, 480};
    r32     = '{32, 0, 0, 1024, 640, 480};
    live    = id_cfg;
    shadow  = id0_cfg;
    hold_chk = 1'b0;

    vt[0] = '{id_cfg, 100, 50, '{1600, 800, 1'b1, 1'b1}};
    vt[1] = '{r90_cfg, 100, 50, '{8160, 320, 1'b1, 1'b1}};
    vt[2] = '{r90_cfg, 600, 0, '{8960, 8320, 1'b0, 1'b1}};
    vt[3] = '{r32, 321, 240, '{5121, 3840, 1'b1, 1'b1}};
    vt[4] = '{r32, 319, 240, '{5120, 3840, 1'b1, 1'b1}};
    vt[5] = '{'{2047, 0, 0, 0, 4094, 4094}, 4095, 2047, '{65535, 32752, 1'b0, 1'b1}};
    vt[6] = '{id0_cfg, 10, 20, '{160, 320, 1'b0, 1'b1}};
    vt[7] = '{id_cfg, 639, 479, '{10224, 7664, 1'b1, 1'b1}};
    vt[8] = '{id_cfg, 640, 479, '{10240, 7664, 1'b0, 1'b1}};
    vt[9] = '{id_cfg, 0, 0, '{0, 0, 1'b1, 1'b1}};

    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || xo !== '0 || yo !== '0 || out_sof !== 1'b0 || in_bounds !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got v=%0b xo=%0d yo=%0d sof=%0b inb=%0b rdy=%0b, required 0 0 0 0 0 1",
               out_valid, xo, yo, out_sof, in_bounds, in_ready);
    end

    // directed vectors, one sof beat each, with latency check
    for (int i = 0; i < 10; i++) begin
      live = vt[i].c;
      want_q.push_back(vt[i].e);
      step(1, 1, vt[i].x, vt[i].y, 1, 0);
      lat = 1;
      while (!out_valid && lat < 10) begin
        step(0, 0, 0, 0, 1, 0);
        lat++;
      end
      checks++;
      if (lat != 3) begin
        errors++;
        $display("FAIL latency[%0d]: got %0d, required 3", i, lat);
      end
      step(0, 0, 0, 0, 1, 0);
    end

    // config switch mid-frame: only a sof beat picks up the new matrix
    live = id_cfg;
    want_q.push_back('{1600, 800, 1'b1, 1'b1});
    step(1, 1, 100, 50, 1, 0);
    live = r90_cfg;
    want_q.push_back('{1600, 800, 1'b1, 1'b0});
    step(1, 0, 100, 50, 1, 0);
    want_q.push_back('{8160, 320, 1'b1, 1'b1});
    step(1, 1, 100, 50, 1, 0);
    want_q.push_back('{8160, 320, 1'b1, 1'b0});
    step(1, 0, 100, 50, 1, 0);
    drain(0);

    // backpressure: 8 beats with out_ready toggling every cycle
    live = id_cfg;
    acc = 0; cyc = 0; n0 = n_out;
    while (acc < 8 && cyc < 100) begin
      step(1, acc == 0, 100 + acc * 10, 50 + acc, cyc % 2 == 0, 0);
      if (last_acc) acc++;
      cyc++;
    end
    drain(1);
    checks++;
    if (n_out - n0 != 8) begin
      errors++;
      $display("FAIL backpressure_count: got %0d outputs, required 8", n_out - n0);
    end

    // reset with three beats in flight
    live = r90_cfg;
    step(1, 1, 100, 50, 1, 0);
    step(1, 0, 200, 60, 1, 0);
    step(1, 0, 300, 70, 1, 0);
    step(0, 0, 0, 0, 1, 1);
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_flush: got v=%0b rdy=%0b, required v=0 rdy=1", out_valid, in_ready);
    end
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0);
    want_q.push_back('{160, 320, 1'b0, 1'b0});
    step(1, 0, 10, 20, 1, 0);
    drain(0);

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        live.m00 = int'($urandom_range(0, 4095)) - 2048;
        live.m01 = int'($urandom_range(0, 4095)) - 2048;
        live.m10 = int'($urandom_range(0, 4095)) - 2048;
        live.m11 = int'($urandom_range(0, 4095)) - 2048;
        live.cols = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 4095)) : 640;
        live.rows = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 4095)) : 480;
      end
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
           int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
           $urandom_range(0, 9) < 7, 0);
    end
    drain(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
